// File: rtl/ece128_pkg.sv
// Shared types and default widths for the ROM-pair sweeper and its compute unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ece128_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } sweeper_state_t;

endpackage

// File: rtl/rom_pair_sweeper_if.sv
// Bundles the sweeper's control, compute-unit and result-RAM signals.
// Latency: n/a (wiring only).
// Backpressure: none; start is a level sampled only while the sweeper is idle.
interface rom_pair_sweeper_if
    import ece128_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr1;
    logic [ADDR_W-1:0] rom_addr2;
    logic [DATA_W-1:0] result;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    // Sweeper side: drives addresses, status and the RAM read data.
    modport master (
        input  start, result, rd_addr,
        output rom_addr1, rom_addr2, busy, done, wr_en, wr_addr, wr_data, rd_data
    );

    // Environment side: kicks off sweeps, supplies results, reads the RAM.
    modport slave (
        output start, result, rd_addr,
        input  rom_addr1, rom_addr2, busy, done, wr_en, wr_addr, wr_data, rd_data
    );
endinterface

// File: rtl/rom_pair_sweeper_result_ram.sv
// Result store: 2^ADDR_W x DATA_W, synchronous write, registered read, cleared on reset.
// Latency: rd_data valid one cycle after rd_addr; a same-cycle write is not visible (old data).
// Backpressure: none; accepts a write every cycle.
module result_ram
    import ece128_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write port and read register; the read samples the array before this edge's write lands.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/rom_pair_sweeper.sv
// Walks NUM_PAIRS address pairs (idx, idx+1) into the compute unit and stores each result.
// Latency: LATENCY+1 cycles per pair; done pulses NUM_PAIRS*(LATENCY+1) cycles after the start edge.
// Backpressure: none; start is ignored while busy or in DONE and is never queued.
module rom_pair_sweeper
    import ece128_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_PAIRS = 8,
    parameter int LATENCY   = 2
)(
    input logic              i_clk,
    input logic              i_reset,
    rom_pair_sweeper_if.master bus
);
    localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_PAIRS - 1);

    sweeper_state_t    r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr1;
    logic [ADDR_W-1:0] r_addr2;
    logic              r_busy;
    logic              r_done;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] w_rd_data;

    // Sweep FSM: all outputs are registered so the compute unit sees glitch-free addresses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_addr1   <= '0;
            r_addr2   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_done  <= 1'b0;
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_idx   <= '0;
                        r_cnt   <= '0;
                        r_addr1 <= '0;
                        r_addr2 <= ADDR_W'(1);
                        r_busy  <= 1'b1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // The result has settled LATENCY edges after the address update.
                    if (r_cnt == CNT_LAST) begin
                        r_wr_data <= bus.result;
                        r_wr_addr <= r_idx;
                        r_wr_en   <= 1'b1;
                        r_state   <= WRITE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    if (r_idx != IDX_LAST) begin
                        r_idx   <= r_idx + ADDR_W'(1);
                        r_addr1 <= r_idx + ADDR_W'(1);
                        r_addr2 <= r_idx + ADDR_W'(2);
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end else begin
                        // Last pair: addresses hold, busy drops as DONE is entered.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    result_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_result_ram (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (r_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (r_wr_data),
        .i_rd_addr (bus.rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign bus.rom_addr1 = r_addr1;
    assign bus.rom_addr2 = r_addr2;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.rd_data   = w_rd_data;
endmodule

// File: tb/tb_rom_pair_sweeper.sv
// Scoreboard bench for rom_pair_sweeper: stimulus pushes expected events, a monitor checks them.
// Latency: expected write/done/read cycles come from the pair-period arithmetic.
// Backpressure: start spamming and mid-sweep resets exercise the ignore/abort paths.
module tb_rom_pair_sweeper;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int NP    = 8;
    localparam int LAT   = 2;
    localparam int PER   = LAT + 1;
    localparam int SWEEP = NP * PER;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    bit   mon_en;
    int   sw_e;
    int   hold_a1;
    int   hold_a2;
    int   model_ram [DEPTH];
    ev_t  q_wr [$];
    int   q_done [$];
    ev_t  q_rd [$];
    logic [DW-1:0] r_res;

    rom_pair_sweeper_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rom_pair_sweeper #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .NUM_PAIRS (NP),
        .LATENCY   (LAT)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Compute-unit stub: {addr1, 0, addr2}, registered once after the address register.
    always @(posedge clk) r_res <= {1'b0, bus.rom_addr1, 1'b0, bus.rom_addr2};
    assign bus.result = r_res;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    function automatic void chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 'h%0h, expected 'h%0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void bad(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s @cyc %0d: got unexpected/missing event, expected none", nm, cyc);
    endfunction

    // Reference: pair i is (i, i+1 mod 2^AW), packed as addr1<<4 | addr2.
    function automatic int exp_data(input int i);
        return ((i % DEPTH) << 4) | ((i + 1) % DEPTH);
    endfunction

    // Monitor: pops scoreboard entries on DUT events and checks per-cycle status.
    always @(negedge clk) begin
        ev_t e;
        int  d;
        if (mon_en) begin
            while (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin
                bad("wr_missed");
                void'(q_wr.pop_front());
            end
            while (q_done.size() > 0 && q_done[0] < cyc) begin
                bad("done_missed");
                void'(q_done.pop_front());
            end
            if (bus.wr_en) begin
                if (q_wr.size() == 0) bad("wr_unexpected");
                else begin
                    e = q_wr.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", int'(bus.wr_addr), e.addr);
                    chk("wr_data", int'(bus.wr_data), e.data);
                end
            end
            if (bus.done) begin
                if (q_done.size() == 0) bad("done_unexpected");
                else chk("done_cycle", cyc, q_done.pop_front());
            end
            if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
                e = q_rd.pop_front();
                chk($sformatf("rd_data[%0d]", e.addr), int'(bus.rd_data), e.data);
            end
            d = cyc - sw_e;
            if (d >= 0 && d < SWEEP) begin
                chk("busy_sweep", int'(bus.busy), 1);
                chk("addr1_sweep", int'(bus.rom_addr1), d / PER);
                chk("addr2_sweep", int'(bus.rom_addr2), (d / PER + 1) % DEPTH);
            end else begin
                chk("busy_idle", int'(bus.busy), 0);
                chk("addr1_idle", int'(bus.rom_addr1), hold_a1);
                chk("addr2_idle", int'(bus.rom_addr2), hold_a2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_check(input int a);
        ev_t e;
        bus.rd_addr = AW'(a);
        e.cyc = cyc + 1; e.addr = a; e.data = model_ram[a];
        q_rd.push_back(e);
        tick();
    endtask

    task automatic reset_mid();
        rst = 1'b1;
        while (q_wr.size() > 0 && q_wr[$].cyc > cyc) void'(q_wr.pop_back());
        while (q_done.size() > 0 && q_done[$] > cyc) void'(q_done.pop_back());
        while (q_rd.size() > 0 && q_rd[$].cyc > cyc) void'(q_rd.pop_back());
        tick();
        bus.start = 1'b0;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_addr1", int'(bus.rom_addr1), 0);
        chk("rst_addr2", int'(bus.rom_addr2), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        rst = 1'b0;
        sw_e = -1000;
        hold_a1 = 0;
        hold_a2 = 0;
        for (int i = 0; i < DEPTH; i++) model_ram[i] = 0;
    endtask

    // One sweep; optional start spamming, reset at sweep cycle rst_at, and reads during WRITE.
    task automatic sweep(input bit spam, input int rst_at, input bit rdw);
        int  e0;
        int  d;
        ev_t e;
        bus.start = 1'b1;
        e0 = cyc + 1;
        for (int i = 0; i < NP; i++) begin
            e.cyc = e0 + PER * i + LAT; e.addr = i; e.data = exp_data(i);
            q_wr.push_back(e);
        end
        q_done.push_back(e0 + SWEEP);
        sw_e = e0;
        tick();
        bus.start = 1'b0;
        hold_a1 = (NP - 1) % DEPTH;
        hold_a2 = NP % DEPTH;
        while (cyc < e0 + SWEEP + 1) begin
            d = cyc - e0;
            if (spam) bus.start = 1'($urandom_range(0, 1));
            if (rdw && d < SWEEP && (d % PER) == LAT) begin
                bus.rd_addr = AW'(d / PER);
                e.cyc = cyc + 1; e.addr = d / PER; e.data = model_ram[d / PER];
                q_rd.push_back(e);
            end
            if (rst_at > 0 && d == rst_at) begin
                reset_mid();
                return;
            end
            tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < NP; i++) model_ram[i % DEPTH] = exp_data(i);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; mon_en = 1'b0; cyc = 0;
        sw_e = -1000; hold_a1 = 0; hold_a2 = 0;
        for (int i = 0; i < DEPTH; i++) model_ram[i] = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.rd_addr = '0;
        repeat (3) tick();
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_wr_en", int'(bus.wr_en), 0);
        chk("reset_addr1", int'(bus.rom_addr1), 0);
        chk("reset_addr2", int'(bus.rom_addr2), 0);
        chk("reset_wr_addr", int'(bus.wr_addr), 0);
        chk("reset_wr_data", int'(bus.wr_data), 0);
        chk("reset_rd_data", int'(bus.rd_data), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        sweep(1'b0, 0, 1'b1);
        for (int a = 0; a < DEPTH; a++) rd_check(a);
        rd_check(5);
        sweep(1'b1, 0, 1'b0);
        sweep(1'b0, 10, 1'b0);
        for (int a = 0; a < DEPTH; a++) rd_check(a);
        sweep(1'b0, 0, 1'b1);
        sweep(1'b0, 0, 1'b1);
        for (int a = 0; a < DEPTH; a++) rd_check(a);

        repeat (8) begin
            repeat ($urandom_range(0, 3)) tick();
            sweep(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, SWEEP - 2)) : 0,
                  1'($urandom_range(0, 1)));
            rd_check(int'($urandom_range(0, DEPTH - 1)));
        end

        repeat (3) tick();
        chk("wr_queue_empty", q_wr.size(), 0);
        chk("done_queue_empty", q_done.size(), 0);
        chk("rd_queue_empty", q_rd.size(), 0);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
